// File: rtl/rand_pkg.sv
// Shared definitions for the rand_mmio front end: register map, FSM encoding
// and register reset values.
package rand_pkg;

    localparam logic [1:0] RAND_ADDR_SEED   = 2'd0;
    localparam logic [1:0] RAND_ADDR_MIN    = 2'd1;
    localparam logic [1:0] RAND_ADDR_MAX    = 2'd2;
    localparam logic [1:0] RAND_ADDR_RESULT = 2'd3;

    localparam logic [7:0] RAND_MIN_RST = 8'd0;
    localparam logic [7:0] RAND_MAX_RST = 8'd255;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCalc = 2'd1,
        StDone = 2'd2
    } rand_state_e;

endpackage

// File: rtl/rand_mod8.sv
// Sequential 8-bit restoring remainder: one quotient bit per cycle, MSB first.
// The 9-bit divisor allows 256, which leaves the dividend unchanged.
module rand_mod8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [8:0] divisor,
    output logic [7:0] rem,
    output logic       done
);

    logic       active_q;
    logic [2:0] cnt_q;
    logic [7:0] dvd_q;
    logic [7:0] rem_q;
    logic [8:0] dsr_q;
    logic [8:0] trial;
    logic [8:0] diff;

    // Partial remainder stays below the divisor, so trial - divisor fits in 8 bits.
    assign trial = {rem_q, dvd_q[7]};
    assign diff  = trial - dsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            cnt_q    <= 3'd0;
            dvd_q    <= 8'd0;
            rem_q    <= 8'd0;
            dsr_q    <= 9'd0;
        end else if (start) begin
            active_q <= 1'b1;
            cnt_q    <= 3'd0;
            dvd_q    <= dividend;
            rem_q    <= 8'd0;
            dsr_q    <= divisor;
        end else if (active_q) begin
            rem_q <= (trial >= dsr_q) ? diff[7:0] : trial[7:0];
            dvd_q <= {dvd_q[6:0], 1'b0};
            cnt_q <= cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                active_q <= 1'b0;
            end
        end
    end

    assign rem  = rem_q;
    assign done = active_q && (cnt_q == 3'd7);

endmodule

// File: rtl/rand_mmio.sv
// CPU-facing register front end for the random LFSR: SEED/MIN/MAX registers,
// seed-load pulse, and a multi-cycle range reduction of the raw byte on RESULT reads.
module rand_mmio
    import rand_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       addr,
    input  logic             w_enable,
    input  logic             r_enable,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] r_data,
    output logic             ready,
    output logic             busy,
    output logic             rnd_w_enable,
    output logic [WIDTH-1:0] rnd_seed,
    input  logic [WIDTH-1:0] rnd_raw
);

    rand_state_e      state_q, state_d;
    logic [WIDTH-1:0] seed_q, min_q, max_q;
    logic [WIDTH-1:0] min_snap_q;
    logic [WIDTH-1:0] reg_data_q;
    logic             reg_ready_q;
    logic             rnd_w_enable_q;
    logic             rd_accept;
    logic             start_calc;
    logic [WIDTH-1:0] span;
    logic [WIDTH:0]   divisor;
    logic [WIDTH-1:0] rem;
    logic             mod_done;

    // A read is only taken when idle with no register read still presenting,
    // and a simultaneous write always wins.
    assign rd_accept  = r_enable && !w_enable && (state_q == StIdle) && !reg_ready_q;
    assign start_calc = rd_accept && (addr == RAND_ADDR_RESULT);

    // Span 0 stands for 256 after the 8-bit wrap.
    assign span    = max_q - min_q + 8'd1;
    assign divisor = (span == '0) ? {1'b1, {WIDTH{1'b0}}} : {1'b0, span};

    rand_mod8 u_mod8 (
        .clk      (clk),
        .rst      (rst),
        .start    (start_calc),
        .dividend (rnd_raw),
        .divisor  (divisor),
        .rem      (rem),
        .done     (mod_done)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (start_calc) state_d = StCalc;
            StCalc: if (mod_done) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            seed_q         <= '0;
            min_q          <= RAND_MIN_RST;
            max_q          <= RAND_MAX_RST;
            min_snap_q     <= '0;
            reg_data_q     <= '0;
            reg_ready_q    <= 1'b0;
            rnd_w_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            rnd_w_enable_q <= w_enable && (addr == RAND_ADDR_SEED);
            reg_ready_q    <= rd_accept && (addr != RAND_ADDR_RESULT);
            if (w_enable) begin
                unique case (addr)
                    RAND_ADDR_SEED:   seed_q <= w_data;
                    RAND_ADDR_MIN:    min_q  <= w_data;
                    RAND_ADDR_MAX:    max_q  <= w_data;
                    RAND_ADDR_RESULT: ;
                    default: ;
                endcase
            end
            if (rd_accept) begin
                unique case (addr)
                    RAND_ADDR_SEED:   reg_data_q <= seed_q;
                    RAND_ADDR_MIN:    reg_data_q <= min_q;
                    RAND_ADDR_MAX:    reg_data_q <= max_q;
                    RAND_ADDR_RESULT: reg_data_q <= reg_data_q;
                    default: ;
                endcase
            end
            if (start_calc) begin
                min_snap_q <= min_q;
            end
        end
    end

    assign busy         = (state_q == StCalc);
    assign ready        = (state_q == StDone) || reg_ready_q;
    assign r_data       = (state_q == StDone) ? (min_snap_q + rem) : reg_data_q;
    assign rnd_w_enable = rnd_w_enable_q;
    assign rnd_seed     = seed_q;

endmodule

// File: tb/tb_rand_mmio.sv
// Scoreboard bench for rand_mmio: stimulus pushes expected read responses,
// a negedge monitor pops and checks data and arrival cycle on every ready.
module tb_rand_mmio;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] addr = 2'd0;
    logic       w_enable = 1'b0;
    logic       r_enable = 1'b0;
    logic [7:0] w_data = 8'd0;
    logic [7:0] r_data;
    logic       ready;
    logic       busy;
    logic       rnd_w_enable;
    logic [7:0] rnd_seed;
    logic [7:0] rnd_raw = 8'd0;

    rand_mmio #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .w_enable     (w_enable),
        .r_enable     (r_enable),
        .w_data       (w_data),
        .r_data       (r_data),
        .ready        (ready),
        .busy         (busy),
        .rnd_w_enable (rnd_w_enable),
        .rnd_seed     (rnd_seed),
        .rnd_raw      (rnd_raw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         cyc;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad = 0;

    // Reference register file
    int seed_m = 0;
    int min_m  = 0;
    int max_m  = 255;

    function automatic int ref_result(int raw, int mn, int mx);
        int span;
        span = (((mx - mn + 1) % 256) + 256) % 256;
        if (span == 0) span = 256;
        return (mn + (raw % span)) % 256;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, need %0d", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'(r_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.name, "_data"}, 32'(r_data), 32'(e.data));
                check({e.name, "_cycle"}, 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic bus_write(input logic [1:0] a, input int d);
        @(negedge clk);
        addr = a; w_data = 8'(d); w_enable = 1'b1;
        case (a)
            2'd0: seed_m = d;
            2'd1: min_m = d;
            2'd2: max_m = d;
            default: ;
        endcase
        @(negedge clk);
        w_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, input bit accept, input string nm);
        exp_t e;
        @(negedge clk);
        addr = a; r_enable = 1'b1;
        if (accept) begin
            case (a)
                2'd0: e.data = 8'(seed_m);
                2'd1: e.data = 8'(min_m);
                2'd2: e.data = 8'(max_m);
                default: e.data = 8'(ref_result(int'(rnd_raw), min_m, max_m));
            endcase
            e.cyc  = cyc + 1 + ((a == 2'd3) ? 8 : 0);
            e.name = nm;
            exp_q.push_back(e);
        end
        @(negedge clk);
        r_enable = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        check("rst_r_data", 32'(r_data), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rnd_w_enable", 32'(rnd_w_enable), 32'd0);
        check("rst_rnd_seed", 32'(rnd_seed), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        bus_read(2'd1, 1'b1, "rd_min_rst");
        bus_read(2'd2, 1'b1, "rd_max_rst");
        drain();
        check("idle_busy", 32'(busy), 32'd0);

        // Basic reduction with busy window
        bus_write(2'd1, 10);
        bus_write(2'd2, 20);
        rnd_raw = 8'd90;
        bus_read(2'd3, 1'b1, "res_10_20_90");
        rnd_raw = 8'd7;
        for (int i = 0; i < 8; i++) begin
            check("calc_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        check("done_busy", 32'(busy), 32'd0);
        drain();

        // Full span and wrapped span
        bus_write(2'd1, 0);
        bus_write(2'd2, 255);
        rnd_raw = 8'd200;
        bus_read(2'd3, 1'b1, "res_span256");
        drain();
        bus_write(2'd1, 200);
        bus_write(2'd2, 10);
        rnd_raw = 8'd90;
        bus_read(2'd3, 1'b1, "res_wrapped");
        drain();

        // Seed load pulse
        @(negedge clk);
        addr = 2'd0; w_data = 8'h5A; w_enable = 1'b1; seed_m = 'h5A;
        @(negedge clk);
        w_enable = 1'b0;
        check("seed_pulse_hi", 32'(rnd_w_enable), 32'd1);
        check("seed_value", 32'(rnd_seed), 32'h5A);
        @(negedge clk);
        check("seed_pulse_lo", 32'(rnd_w_enable), 32'd0);
        bus_read(2'd0, 1'b1, "rd_seed");
        drain();

        // Writes and reads during CALC
        bus_write(2'd1, 10);
        bus_write(2'd2, 20);
        rnd_raw = 8'd90;
        bus_read(2'd3, 1'b1, "res_snapshot");
        bus_write(2'd2, 15);
        bus_read(2'd3, 1'b0, "dropped");
        drain();
        rnd_raw = 8'd90;
        bus_read(2'd3, 1'b1, "res_new_max");
        drain();

        // Simultaneous write and read: write wins, read dropped
        @(negedge clk);
        addr = 2'd1; w_data = 8'd33; w_enable = 1'b1; r_enable = 1'b1; min_m = 33;
        @(negedge clk);
        w_enable = 1'b0; r_enable = 1'b0;
        repeat (3) @(negedge clk);
        bus_read(2'd1, 1'b1, "rd_min_after_wr");
        drain();

        // Randomized traffic
        for (int it = 0; it < 30; it++) begin
            bus_write(2'd1, int'($urandom_range(0, 255)));
            bus_write(2'd2, int'($urandom_range(0, 255)));
            rnd_raw = 8'($urandom_range(0, 255));
            bus_read(2'd3, 1'b1, "rand_result");
            rnd_raw = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) bus_write(2'd1, int'($urandom_range(0, 255)));
            drain();
            bus_read(2'($urandom_range(0, 2)), 1'b1, "rand_reg");
            drain();
        end

        // Reset in the 4th CALC cycle
        bus_write(2'd0, 'h33);
        bus_write(2'd1, 5);
        bus_write(2'd2, 50);
        rnd_raw = 8'd77;
        bus_read(2'd3, 1'b1, "aborted");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        seed_m = 0; min_m = 0; max_m = 255;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        bus_read(2'd1, 1'b1, "rd_min_post_rst");
        bus_read(2'd2, 1'b1, "rd_max_post_rst");
        drain();
        check("post_rst_seed", 32'(rnd_seed), 32'd0);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, need finished");
        $fatal(1, "timeout");
    end

endmodule
